// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and lane-extract helper for the polynomial datapath.
package kyber_pkg;

    localparam int unsigned KYBER_Q    = 3329;
    localparam int unsigned COEFF_W    = 12;
    localparam int unsigned LANES      = 8;
    localparam int unsigned POLY_WORDS = 32;
    localparam int unsigned RAM_AW     = 8;
    localparam int unsigned RAM_DW     = LANES * COEFF_W;
    localparam int unsigned LANE_W     = 3;
    localparam int unsigned WORD_W     = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } stream_state_e;

    // Lane k of a RAM word occupies bits [12k+11:12k].
    function automatic logic [COEFF_W-1:0] coeff_lane(input logic [RAM_DW-1:0] word,
                                                      input logic [LANE_W-1:0] lane);
        return word[32'(lane) * COEFF_W +: COEFF_W];
    endfunction

endpackage

// File: rtl/mod_q_csub.sv
// Single conditional subtraction of Q: maps any CW-bit value below 2Q into [0, Q-1].
module mod_q_csub #(
    parameter int unsigned CW = 12,
    parameter int unsigned Q  = 3329
) (
    input  logic [CW-1:0] a,
    output logic [CW-1:0] y
);

    localparam logic [CW-1:0] QV = CW'(Q);

    assign y = (a >= QV) ? a - QV : a;

endmodule

// File: rtl/poly_coeff_streamer.sv
// Streams one 256-coefficient polynomial from the 96-bit polynomial RAM, one canonical
// coefficient per cycle, using a two-word ping-pong prefetch buffer to hide read latency.
module poly_coeff_streamer
    import kyber_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [RAM_AW-1:0]   r_start_offset,
    output logic [RAM_AW-1:0]   r_data_addr,
    output logic                r_data_en,
    input  logic [RAM_DW-1:0]   r_data,
    output logic [COEFF_W-1:0]  coeff_data,
    output logic [RAM_AW-1:0]   coeff_idx,
    output logic                coeff_valid,
    input  logic                coeff_ready,
    output logic                coeff_last,
    output logic                busy,
    output logic                done
);

    stream_state_e      state_q;
    logic [RAM_AW-1:0]  offset_q;
    logic [WORD_W:0]    rd_cnt_q;     // words requested, 0..32
    logic [WORD_W-1:0]  emit_word_q;  // word currently being emitted
    logic [LANE_W-1:0]  lane_q;
    logic [RAM_DW-1:0]  pp_buf_q [2];
    logic [1:0]         full_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic               inflight_q;   // read issued last cycle; r_data valid now

    logic               xfer;
    logic               free_now;
    logic [1:0]         n_free;
    logic [COEFF_W-1:0] raw_coeff;

    // Read issue: a slot must remain after reserving one for the read already in flight.
    // A buffer freed by this cycle's lane-7 transfer counts as available.
    always_comb begin
        xfer        = coeff_valid & coeff_ready;
        free_now    = xfer && (lane_q == 3'd7);
        n_free      = {1'b0, ~full_q[0]} + {1'b0, ~full_q[1]} + {1'b0, free_now};
        r_data_en   = (state_q == StRun) && (rd_cnt_q < 6'(POLY_WORDS))
                      && (n_free > {1'b0, inflight_q});
        r_data_addr = offset_q + RAM_AW'(rd_cnt_q[WORD_W-1:0]);
    end

    // Emit side: unregistered mux of the read-pointer buffer lane.
    always_comb begin
        coeff_valid = (state_q == StRun) && full_q[rd_ptr_q];
        raw_coeff   = coeff_lane(pp_buf_q[rd_ptr_q], lane_q);
        coeff_idx   = {emit_word_q, lane_q};
        coeff_last  = coeff_valid && (coeff_idx == 8'hFF);
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
    end

    mod_q_csub #(
        .CW (COEFF_W),
        .Q  (KYBER_Q)
    ) u_csub (
        .a (raw_coeff),
        .y (coeff_data)
    );

    // FSM, counters and ping-pong buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            offset_q    <= '0;
            rd_cnt_q    <= '0;
            emit_word_q <= '0;
            lane_q      <= '0;
            pp_buf_q[0] <= '0;
            pp_buf_q[1] <= '0;
            full_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRun;
                        offset_q    <= r_start_offset;
                        rd_cnt_q    <= '0;
                        emit_word_q <= '0;
                        lane_q      <= '0;
                        full_q      <= '0;
                        wr_ptr_q    <= 1'b0;
                        rd_ptr_q    <= 1'b0;
                        inflight_q  <= 1'b0;
                    end
                end
                StRun: begin
                    inflight_q <= r_data_en;
                    if (r_data_en) begin
                        rd_cnt_q <= rd_cnt_q + 6'd1;
                    end
                    // Capture goes to the empty buffer; free clears the full one, never the same.
                    if (inflight_q) begin
                        pp_buf_q[wr_ptr_q] <= r_data;
                        full_q[wr_ptr_q]   <= 1'b1;
                        wr_ptr_q           <= ~wr_ptr_q;
                    end
                    if (xfer) begin
                        lane_q <= lane_q + 3'd1;
                        if (lane_q == 3'd7) begin
                            full_q[rd_ptr_q] <= 1'b0;
                            rd_ptr_q         <= ~rd_ptr_q;
                            emit_word_q      <= emit_word_q + 5'd1;
                            if (emit_word_q == 5'd31) begin
                                state_q <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
